// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the decode stage and the hazard controller.
// Decode drives the instruction fields; the controller drives stall/forward selects.
interface pipe_hazard_ctrl_if #(
  parameter int RW    = 5,
  parameter int DEPTH = 3,
  parameter int FW    = 2
);
  logic             id_valid;
  logic [RW-1:0]    id_rs1;
  logic [RW-1:0]    id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [RW-1:0]    id_rd;
  logic             id_regwrite;
  logic             id_load;
  logic             id_multi;
  logic             id_flush;
  logic             stall;
  logic             busy;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic [DEPTH-1:0] stage_valid;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2,
    output id_rd, id_regwrite, id_load, id_multi, id_flush,
    input  stall, busy, fwd_a, fwd_b, stage_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2,
    input  id_rd, id_regwrite, id_load, id_multi, id_flush,
    output stall, busy, fwd_a, fwd_b, stage_valid
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow pipeline of pending writes,
// forwarding selects, load-use stall, multi-cycle freeze, flush bubbles.
module pipe_hazard_ctrl #(
  parameter int NREG   = 32,
  parameter int RW     = 5,
  parameter int DEPTH  = 3,
  parameter int MULCYC = 4,
  parameter int FW     = 2
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CW = $clog2(MULCYC);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_wr;
  logic [DEPTH-1:0] r_ld;
  logic [RW-1:0]    r_rd [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;
  logic             w_ok1;
  logic             w_ok2;
  logic [FW-1:0]    w_fwd_a;
  logic [FW-1:0]    w_fwd_b;
  logic             w_lu;
  logic             w_stall;
  logic             w_take;

  // r0 is hardwired zero, so it never names a producer
  always_comb begin
    w_ok1 = bus.id_use1 && (bus.id_rs1 != '0)
         && (int'(bus.id_rs1) < NREG);
    w_ok2 = bus.id_use2 && (bus.id_rs2 != '0)
         && (int'(bus.id_rs2) < NREG);
    for (int i = 0; i < DEPTH; i++) begin
      w_m1[i] = r_valid[i] && r_wr[i]
             && (r_rd[i] == bus.id_rs1) && w_ok1;
      w_m2[i] = r_valid[i] && r_wr[i]
             && (r_rd[i] == bus.id_rs2) && w_ok2;
    end
  end

  // scan oldest to youngest so the youngest producer ends up selected
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_m1[i]) w_fwd_a = FW'(i + 1);
      if (w_m2[i]) w_fwd_b = FW'(i + 1);
    end
  end

  assign w_lu    = r_ld[0] && (w_m1[0] || w_m2[0]);
  assign w_stall = r_busy || w_lu;
  assign w_take  = bus.id_valid && !w_stall && !bus.id_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_wr    <= '0;
      r_ld    <= '0;
      for (int i = 0; i < DEPTH; i++) r_rd[i] <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_valid[i] <= r_valid[i-1];
        r_wr[i]    <= r_wr[i-1];
        r_ld[i]    <= r_ld[i-1];
        r_rd[i]    <= r_rd[i-1];
      end
      r_valid[0] <= w_take;
      r_wr[0]    <= w_take && bus.id_regwrite;
      r_ld[0]    <= w_take && bus.id_load;
      r_rd[0]    <= w_take ? bus.id_rd : '0;
      if (w_take && bus.id_multi) begin
        r_cnt  <= CW'(MULCYC - 1);
        r_busy <= 1'b1;
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.busy        = r_busy;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stage_valid = r_valid;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// compared against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int NREG   = 32;
  localparam int RW     = 5;
  localparam int DEPTH  = 3;
  localparam int MULCYC = 4;
  localparam int FW     = 2;

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2;
    int rd; bit wr; bit ld; bit mu; bit fl;
  } in_t;

  typedef struct { bit v; int rd; bit wr; bit ld; } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  ent_t m [DEPTH];
  int   m_freeze;

  pipe_hazard_ctrl_if #(.RW(RW), .DEPTH(DEPTH), .FW(FW)) bus ();

  pipe_hazard_ctrl #(
    .NREG(NREG), .RW(RW), .DEPTH(DEPTH),
    .MULCYC(MULCYC), .FW(FW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  function automatic in_t mk(bit v, int rs1, bit u1, int rs2, bit u2,
                             int rd, bit wr, bit ld, bit mu, bit fl);
    in_t x;
    x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
    x.rd = rd; x.wr = wr; x.ld = ld; x.mu = mu; x.fl = fl;
    return x;
  endfunction

  // nearest in-flight producer of src, counted from exec as 1
  function automatic int efwd(int src, bit u);
    if (!u || src == 0) return 0;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].v && m[i].wr && m[i].rd == src) return i + 1;
    return 0;
  endfunction

  function automatic bit e_stall(in_t x);
    bit lu;
    lu = m[0].ld && (efwd(x.rs1, x.u1) == 1 || efwd(x.rs2, x.u2) == 1);
    return (m_freeze > 0) || lu;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{0, 0, 0, 0};
    m_freeze = 0;
  endtask

  task automatic model_edge(in_t x);
    bit st;
    st = e_stall(x);
    if (m_freeze > 0) begin
      m_freeze--;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) m[i] = m[i-1];
      if (x.v && !st && !x.fl) begin
        m[0] = '{1, x.rd, x.wr, x.ld};
        if (x.mu) m_freeze = MULCYC - 1;
      end else begin
        m[0] = '{0, 0, 0, 0};
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(in_t x);
    bus.id_valid    = x.v;
    bus.id_rs1      = RW'(x.rs1);
    bus.id_use1     = x.u1;
    bus.id_rs2      = RW'(x.rs2);
    bus.id_use2     = x.u2;
    bus.id_rd       = RW'(x.rd);
    bus.id_regwrite = x.wr;
    bus.id_load     = x.ld;
    bus.id_multi    = x.mu;
    bus.id_flush    = x.fl;
  endtask

  task automatic check_all(in_t x);
    logic [DEPTH-1:0] sv;
    for (int i = 0; i < DEPTH; i++) sv[i] = m[i].v;
    chk("stall", 32'(bus.stall), 32'(e_stall(x)));
    chk("busy", 32'(bus.busy), 32'(m_freeze > 0));
    chk("fwd_a", 32'(bus.fwd_a), 32'(efwd(x.rs1, x.u1)));
    chk("fwd_b", 32'(bus.fwd_b), 32'(efwd(x.rs2, x.u2)));
    chk("stage_valid", 32'(bus.stage_valid), 32'(sv));
  endtask

  // drive just after a rising edge, check mid-cycle, advance model at edge
  task automatic step(in_t x);
    drive(x);
    @(negedge clock);
    check_all(x);
    @(posedge clock);
    model_edge(x);
    #1;
  endtask

  in_t idle;
  in_t r;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    model_reset();
    #3;
    check_all(idle);
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    step(idle);

    // RAW distances 1, 2, then beyond depth
    step(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0));
    step(mk(1, 3, 1, 4, 1, 10, 1, 0, 0, 0));
    step(mk(1, 3, 1, 0, 0, 11, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0));
    step(mk(1, 3, 1, 3, 1, 13, 1, 0, 0, 0));

    // youngest writer wins
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    step(mk(1, 5, 1, 5, 1, 14, 1, 0, 0, 0));

    // load-use on rs2: one stall, then forward from entry 1
    step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0));
    step(mk(1, 1, 1, 7, 1, 15, 1, 0, 0, 0));
    step(mk(1, 1, 1, 7, 1, 15, 1, 0, 0, 0));

    // r0 writer never forwards or stalls
    step(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step(mk(1, 0, 1, 0, 1, 16, 1, 0, 0, 0));

    // multi-cycle freeze with dependent reader held in decode
    step(mk(1, 1, 1, 2, 1, 9, 1, 0, 1, 0));
    for (int k = 0; k < MULCYC + 1; k++)
      step(mk(1, 9, 1, 9, 1, 17, 1, 0, 0, 0));

    // flush beats load-use
    step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0));
    step(mk(1, 7, 1, 7, 1, 18, 1, 0, 0, 1));
    step(idle);

    // async reset in the middle of a freeze
    step(mk(1, 1, 1, 2, 1, 9, 1, 0, 1, 0));
    step(idle);
    #2 reset = 1'b0;
    #1;
    model_reset();
    drive(idle);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_valid", 32'(bus.stage_valid), 32'(0));
    chk("rst_stall", 32'(bus.stall), 32'(0));
    @(posedge clock);
    #1 reset = 1'b1;
    step(idle);

    for (int n = 0; n < 400; n++) begin
      r.v   = ($urandom_range(0, 9) != 0);
      r.rs1 = int'($urandom_range(0, 7));
      r.rs2 = int'($urandom_range(0, 7));
      r.u1  = $urandom_range(0, 3) != 0;
      r.u2  = $urandom_range(0, 3) != 0;
      r.rd  = int'($urandom_range(0, 7));
      r.wr  = $urandom_range(0, 4) != 0;
      r.ld  = $urandom_range(0, 3) == 0;
      r.mu  = $urandom_range(0, 15) == 0;
      r.fl  = $urandom_range(0, 9) == 0;
      step(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
